// File: rtl/gate_test_sequencer.sv
// Exhaustive tester for a 2-input gate: walks vectors 00..11, lets each settle DIV cycles,
// then checks dut_out against the truth table chosen by op. Repeats for LOOPS passes.
module gate_test_sequencer #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned LOOPS = 1,
   parameter int unsigned CW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [2:0]    op,
   input  logic          dut_out,
   output logic          in1,
   output logic          in0,
   output logic [1:0]    vec_idx,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic          cfg_err,
   output logic [CW-1:0] err_cnt,
   output logic [3:0]    fail_mask
);

   localparam int unsigned   DW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned   LW        = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);
   localparam logic [CW-1:0] ERR_MAX   = {CW{1'b1}};

   typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

   state_e        state;
   logic [2:0]    op_latched;
   logic [DW-1:0] div_cnt;
   logic [LW-1:0] loop;
   logic          exp_out;
   logic          mismatch;
   logic [CW-1:0] err_next;

   // The gate inputs always mirror the registered vector index.
   assign {in1, in0} = vec_idx;

   always_comb begin
      exp_out = 1'b0;
      case (op_latched)
         3'd0:    exp_out = in1 & in0;
         3'd1:    exp_out = in1 | in0;
         3'd2:    exp_out = in1 ^ in0;
         3'd3:    exp_out = ~(in1 & in0);
         3'd4:    exp_out = ~(in1 | in0);
         3'd5:    exp_out = ~(in1 ^ in0);
         default: exp_out = 1'b0;
      endcase
   end

   assign mismatch = (dut_out != exp_out);
   assign err_next = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         op_latched <= 3'd0;
         div_cnt    <= '0;
         loop       <= '0;
         vec_idx    <= 2'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         cfg_err    <= 1'b0;
         err_cnt    <= '0;
         fail_mask  <= 4'd0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  op_latched <= op;
                  err_cnt    <= '0;
                  fail_mask  <= 4'd0;
                  pass       <= 1'b0;
                  loop       <= '0;
                  vec_idx    <= 2'd0;
                  div_cnt    <= '0;
                  if (op >= 3'd6) begin
                     state   <= StDone;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     cfg_err <= 1'b1;
                  end else begin
                     state   <= StApply;
                     busy    <= 1'b1;
                     done    <= 1'b0;
                     cfg_err <= 1'b0;
                  end
               end
            end

            StApply: begin
               if (abort) begin
                  state   <= StIdle;
                  vec_idx <= 2'd0;
                  div_cnt <= '0;
                  loop    <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else if (div_cnt == DIV_LAST) begin
                  state <= StCheck;
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end

            StCheck: begin
               if (abort) begin
                  // Abort discards this cycle's comparison; partial results stay visible.
                  state   <= StIdle;
                  vec_idx <= 2'd0;
                  div_cnt <= '0;
                  loop    <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end else begin
                  if (mismatch) begin
                     err_cnt            <= err_next;
                     fail_mask[vec_idx] <= 1'b1;
                  end
                  div_cnt <= '0;
                  if (vec_idx != 2'd3) begin
                     vec_idx <= vec_idx + 2'd1;
                     state   <= StApply;
                  end else if (loop != LOOP_LAST) begin
                     loop    <= loop + LW'(1);
                     vec_idx <= 2'd0;
                     state   <= StApply;
                  end else begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= !mismatch && (err_cnt == '0) && !cfg_err;
                  end
               end
            end
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(busy && done));
   assert property (@(posedge clk) disable iff (rst) busy |-> !cfg_err);

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: a run-timeline model checked every cycle, directed scenarios,
// and two extra instances covering multi-loop runs and error-count saturation.
module tb_gate_test_sequencer;

   localparam int unsigned DIV   = 4;
   localparam int unsigned LOOPS = 1;
   localparam int unsigned CW    = 8;
   localparam int          PER   = DIV + 1;
   localparam int          TOTAL = 4 * LOOPS * PER;

   logic          clk = 1'b0;
   logic          rst, start, abort, dut_out;
   logic [2:0]    op;
   logic          in1, in0, busy, done, pass, cfg_err;
   logic [1:0]    vec_idx;
   logic [CW-1:0] err_cnt;
   logic [3:0]    fail_mask;

   // Behaviour of the gate under test for the main instance.
   logic [2:0] dut_fn;
   logic       tie0;

   // Instances B (CW=8) and C (CW=2): DIV=3, LOOPS=3, op=XOR, gate is XNOR.
   logic       start_b, abort_b;
   logic [2:0] op_b;
   logic       dut_out_b, in1_b, in0_b, busy_b, done_b, pass_b, cfg_b;
   logic [1:0] vec_b;
   logic [7:0] err_b;
   logic [3:0] mask_b;
   logic       dut_out_c, in1_c, in0_c, busy_c, done_c, pass_c, cfg_c;
   logic [1:0] vec_c;
   logic [1:0] err_c;
   logic [3:0] mask_c;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   gate_test_sequencer #(.DIV(DIV), .LOOPS(LOOPS), .CW(CW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op), .dut_out(dut_out),
      .in1(in1), .in0(in0), .vec_idx(vec_idx), .busy(busy), .done(done), .pass(pass),
      .cfg_err(cfg_err), .err_cnt(err_cnt), .fail_mask(fail_mask)
   );

   gate_test_sequencer #(.DIV(3), .LOOPS(3), .CW(8)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .op(op_b), .dut_out(dut_out_b),
      .in1(in1_b), .in0(in0_b), .vec_idx(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .cfg_err(cfg_b), .err_cnt(err_b), .fail_mask(mask_b)
   );

   gate_test_sequencer #(.DIV(3), .LOOPS(3), .CW(2)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .op(op_b), .dut_out(dut_out_c),
      .in1(in1_c), .in0(in0_c), .vec_idx(vec_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .cfg_err(cfg_c), .err_cnt(err_c), .fail_mask(mask_c)
   );

   function automatic logic gate(input logic [2:0] f, input logic [1:0] v);
      case (f)
         3'd0:    return v[1] & v[0];
         3'd1:    return v[1] | v[0];
         3'd2:    return v[1] ^ v[0];
         3'd3:    return ~(v[1] & v[0]);
         3'd4:    return ~(v[1] | v[0]);
         3'd5:    return ~(v[1] ^ v[0]);
         default: return 1'b0;
      endcase
   endfunction

   assign dut_out   = tie0 ? 1'b0 : gate(dut_fn, {in1, in0});
   assign dut_out_b = ~(in1_b ^ in0_b);
   assign dut_out_c = ~(in1_c ^ in0_c);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Results after e edges of a run: every (DIV+1)th edge completes one vector check.
   function automatic void run_stats(input logic [2:0] rop, input int e,
                                     output int err, output logic [3:0] mask);
      int c;
      logic [1:0] v;
      logic dv;
      err  = 0;
      mask = 4'd0;
      c    = e / PER;
      if (c > 4 * LOOPS) c = 4 * LOOPS;
      for (int j = 0; j < c; j++) begin
         v  = 2'(j % 4);
         dv = tie0 ? 1'b0 : gate(dut_fn, v);
         if (dv != gate(rop, v)) begin
            if (err < (1 << CW) - 1) err++;
            mask[v] = 1'b1;
         end
      end
   endfunction

   typedef enum int {MUnk, MIdle, MRun, MDone} mmode_e;
   mmode_e     m_mode = MUnk;
   int         m_t0   = 0;
   int         m_err  = 0;
   logic [2:0] m_op   = 3'd0;
   logic [3:0] m_mask = 4'd0;
   logic       m_cfg  = 1'b0;
   logic       m_pass = 1'b0;
   logic [1:0] m_vec  = 2'd0;

   always @(posedge clk) begin
      int er;
      logic [3:0] mk;
      cyc <= cyc + 1;
      if (rst) begin
         m_mode <= MIdle;
         m_err  <= 0;
         m_mask <= 4'd0;
         m_cfg  <= 1'b0;
         m_pass <= 1'b0;
         m_vec  <= 2'd0;
      end else if (m_mode == MRun) begin
         if (abort) begin
            run_stats(m_op, cyc - m_t0, er, mk);
            m_mode <= MIdle;
            m_err  <= er;
            m_mask <= mk;
            m_vec  <= 2'd0;
            m_pass <= 1'b0;
         end else if (cyc + 1 - m_t0 == TOTAL) begin
            run_stats(m_op, TOTAL, er, mk);
            m_mode <= MDone;
            m_err  <= er;
            m_mask <= mk;
            m_pass <= (er == 0);
            m_vec  <= 2'd3;
         end
      end else if (m_mode != MUnk && start) begin
         m_err  <= 0;
         m_mask <= 4'd0;
         m_pass <= 1'b0;
         m_vec  <= 2'd0;
         if (op >= 3'd6) begin
            m_mode <= MDone;
            m_cfg  <= 1'b1;
         end else begin
            m_mode <= MRun;
            m_cfg  <= 1'b0;
            m_t0   <= cyc + 1;
            m_op   <= op;
         end
      end
   end

   always @(negedge clk) begin
      int er, e;
      logic [3:0] mk;
      logic [1:0] v;
      logic bz, dn, ps, cf;
      logic [19:0] act, exp;
      if (m_mode != MUnk) begin
         if (m_mode == MRun) begin
            e = cyc - m_t0;
            run_stats(m_op, e, er, mk);
            v  = 2'((e / PER) % 4);
            bz = 1'b1;
            dn = 1'b0;
            ps = 1'b0;
            cf = 1'b0;
         end else begin
            er = m_err;
            mk = m_mask;
            v  = m_vec;
            bz = 1'b0;
            dn = (m_mode == MDone);
            ps = m_pass;
            cf = m_cfg;
         end
         exp = {v, v, bz, dn, ps, cf, CW'(er), mk};
         act = {in1, in0, vec_idx, busy, done, pass, cfg_err, err_cnt, fail_mask};
         check("cycle", act, exp);
      end
   end

   task automatic pulse_start(output int ts);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ts = cyc;
   endtask

   task automatic wait_done(input int ts, output int lat);
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            lat = cyc - ts + 1;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got done=0 expected done=1 within 200 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int ts, lat;
      rst = 1'b1; start = 1'b0; abort = 1'b0; op = 3'd0;
      dut_fn = 3'd0; tie0 = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; op_b = 3'd2;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_flags", {busy, done, pass, cfg_err}, 4'b0000);
      check("reset_err", err_cnt, 0);
      check("reset_vec", {in1, in0, vec_idx}, 4'b0000);

      // B/C: 12 checks, all mismatch; done visible for sampling at T+1+12*4.
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      ts  = cyc;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         if (done_b) begin
            lat = cyc - ts + 1;
            break;
         end
         @(negedge clk);
      end
      check("b_latency", lat, 49);
      check("b_err", err_b, 12);
      check("b_mask", mask_b, 4'hf);
      check("b_pass", pass_b, 0);
      check("c_err_sat", err_c, 3);
      check("c_mask", mask_c, 4'hf);

      // AND op against an AND gate.
      op = 3'd0;
      pulse_start(ts);
      check("t1_busy", {busy, in1, in0}, 3'b100);
      wait_done(ts, lat);
      check("t1_latency", lat, 21);
      check("t1_result", {pass, err_cnt, fail_mask}, {1'b1, 8'd0, 4'b0000});

      // Output stuck at 0: only vector 11 fails.
      tie0 = 1'b1;
      pulse_start(ts);
      wait_done(ts, lat);
      check("t2_result", {pass, err_cnt, fail_mask}, {1'b0, 8'd1, 4'b1000});

      // NAND expected from an AND gate: every vector fails.
      tie0 = 1'b0;
      op   = 3'd3;
      pulse_start(ts);
      wait_done(ts, lat);
      check("t3_result", {pass, err_cnt, fail_mask}, {1'b0, 8'd4, 4'b1111});

      // Illegal op.
      op = 3'd7;
      pulse_start(ts);
      check("t4_cfg", {done, cfg_err, pass, busy, in1, in0}, 6'b110000);
      repeat (3) @(negedge clk);

      // OR expected from AND gate; abort (with a simultaneous start) in vector 2 APPLY.
      op = 3'd1;
      pulse_start(ts);
      repeat (11) @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("t5_abort", {busy, done, in1, in0, vec_idx}, 6'b000000);
      check("t5_partial", {err_cnt, fail_mask}, {8'd1, 4'b0010});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      // start beats abort when idle
      op    = 3'd0;
      abort = 1'b1;
      pulse_start(ts);
      abort = 1'b0;
      check("t5_restart", {busy, err_cnt, fail_mask}, {1'b1, 8'd0, 4'b0000});
      wait_done(ts, lat);
      check("t5_pass", pass, 1);

      // Start pulses and an op change mid-run are ignored; reset in vector 1 CHECK.
      pulse_start(ts);
      repeat (2) @(negedge clk);
      start = 1'b1;
      op    = 3'd7;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_pre_rst", {busy, vec_idx}, 3'b101);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_reset", {in1, in0, vec_idx, busy, done, pass, cfg_err, err_cnt, fail_mask},
            20'd0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
